// File: rtl/load_store_unit.sv
// Load/store unit: turns a decoded load/store into one valid/ready data-memory
// transaction, with store lane steering, load extension and fault reporting.
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              lsu_busy,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              fault_valid,
  output logic [1:0]        fault_code,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic [1:0]       offset_q;

  logic        req_any;
  logic        illegal;
  logic        misaligned;
  logic        timeout_hit;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] rsp_shift;
  logic [31:0] load_ext;

  always_comb begin
    req_any    = req_read | req_write;
    // funct3[1:0]==11 is never legal; stores additionally reject all unsigned forms
    illegal    = (req_read & req_write) | (funct3[1:0] == 2'b11) |
                 (req_write & funct3[2]) | (funct3 == 3'b110);
    misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    timeout_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    st_wdata = wdata;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{wdata[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata[15:0]}};
        st_wstrb = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase

    rsp_shift = mem_rsp_rdata >> {offset_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & rsp_shift[7]}}, rsp_shift[7:0]};
      2'b01:   load_ext = {{16{~unsigned_q & rsp_shift[15]}}, rsp_shift[15:0]};
      default: load_ext = mem_rsp_rdata;
    endcase
  end

  // Combinational in IDLE so the stall appears in the same cycle as the request.
  assign lsu_busy = ((state == IDLE) & req_any) | (state == REQ) | (state == RSP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      offset_q      <= 2'b00;
      load_valid    <= 1'b0;
      load_data     <= '0;
      fault_valid   <= 1'b0;
      fault_code    <= 2'b00;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
    end else begin
      load_valid  <= 1'b0;
      fault_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            if (illegal) begin
              state       <= DONE;
              fault_valid <= 1'b1;
              fault_code  <= 2'b11;
            end else if (misaligned) begin
              state       <= DONE;
              fault_valid <= 1'b1;
              fault_code  <= 2'b01;
            end else begin
              state         <= REQ;
              tmo_cnt       <= '0;
              size_q        <= funct3[1:0];
              unsigned_q    <= funct3[2];
              offset_q      <= addr[1:0];
              mem_req_valid <= 1'b1;
              mem_req_we    <= req_write;
              mem_addr      <= {addr[ADDR_W-1:2], 2'b00};
              mem_wdata     <= req_write ? st_wdata : 32'd0;
              mem_wstrb     <= req_write ? st_wstrb : 4'b0000;
            end
          end
        end
        REQ: begin
          if (timeout_hit) begin
            state         <= DONE;
            mem_req_valid <= 1'b0;
            fault_valid   <= 1'b1;
            fault_code    <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (mem_req_ready) begin
              state         <= RSP;
              mem_req_valid <= 1'b0;
            end
          end
        end
        RSP: begin
          // Timeout takes priority over a response arriving on the same edge.
          if (timeout_hit) begin
            state       <= DONE;
            fault_valid <= 1'b1;
            fault_code  <= 2'b10;
          end else if (mem_rsp_valid) begin
            state <= DONE;
            if (!mem_req_we) begin
              load_valid <= 1'b1;
              load_data  <= load_ext;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          fault_code <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
